// File: rtl/age_ordered_rs.sv
// age_ordered_rs
//   Parametrised reservation station with oldest-first issue. Entries are
//   written by up to DISPATCH_WIDTH lanes per cycle, woken up by CDB_WIDTH
//   result broadcasts, and issued on up to ISSUE_WIDTH FU ports. Issue order
//   is by ROB age measured from i_rob_head, modulo 2^TAG_W.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_flush                synchronous squash of every entry
//   i_disp_*, o_disp_rdy   dispatch lanes (flattened, lane l at [l*W +: W])
//   i_fu_rdy, o_iss_*      issue ports (flattened, port p at [p*W +: W])
//   i_cdb_*                wakeup broadcasts (flattened, port c at [c*W +: W])
//   i_rob_head             oldest in-flight ROB tag, age reference
//   o_occupancy            number of valid entries
//
// Optional feature: define RS_PERF_CNT_EN to add the saturating performance
// counters o_perf_full_cycles and o_perf_issued.

module age_ordered_rs #(
  parameter int NUM_ENTRIES    = 8,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int TAG_W          = 5,
  parameter int DATA_W         = 32,
  parameter int PAYLOAD_W      = 32,
  localparam int OCC_W         = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_flush,
  input  logic [DISPATCH_WIDTH-1:0]           i_disp_valid,
  output logic [DISPATCH_WIDTH-1:0]           o_disp_rdy,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]     i_disp_rob_tag,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]     i_disp_src1_tag,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]     i_disp_src2_tag,
  input  logic [DISPATCH_WIDTH-1:0]           i_disp_src1_rdy,
  input  logic [DISPATCH_WIDTH-1:0]           i_disp_src2_rdy,
  input  logic [DISPATCH_WIDTH*DATA_W-1:0]    i_disp_src1_val,
  input  logic [DISPATCH_WIDTH*DATA_W-1:0]    i_disp_src2_val,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] i_disp_payload,
  input  logic [ISSUE_WIDTH-1:0]              i_fu_rdy,
  output logic [ISSUE_WIDTH-1:0]              o_iss_valid,
  output logic [ISSUE_WIDTH*TAG_W-1:0]        o_iss_rob_tag,
  output logic [ISSUE_WIDTH*DATA_W-1:0]       o_iss_src1_val,
  output logic [ISSUE_WIDTH*DATA_W-1:0]       o_iss_src2_val,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]    o_iss_payload,
  input  logic [CDB_WIDTH-1:0]                i_cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]          i_cdb_tag,
  input  logic [CDB_WIDTH*DATA_W-1:0]         i_cdb_data,
  input  logic [TAG_W-1:0]                    i_rob_head,
  output logic [OCC_W-1:0]                    o_occupancy
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                         o_perf_full_cycles,
  output logic [31:0]                         o_perf_issued
`endif
);

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int LANE_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  // Entry storage
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_rob_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_s1_tag   [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_s2_tag   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_s1_rdy;
  logic [NUM_ENTRIES-1:0] r_s2_rdy;
  logic [DATA_W-1:0]      r_s1_val   [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_s2_val   [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   r_payload  [NUM_ENTRIES];

  logic [OCC_W-1:0]       w_occ;

  // Lane fields, operands already snooped against the CDB ({rdy, val})
  logic [TAG_W-1:0]       w_l_tag    [DISPATCH_WIDTH];
  logic [TAG_W-1:0]       w_l_s1_tag [DISPATCH_WIDTH];
  logic [TAG_W-1:0]       w_l_s2_tag [DISPATCH_WIDTH];
  logic [DATA_W:0]        w_l_s1     [DISPATCH_WIDTH];
  logic [DATA_W:0]        w_l_s2     [DISPATCH_WIDTH];
  logic [PAYLOAD_W-1:0]   w_l_pl     [DISPATCH_WIDTH];

  // Entry wakeup next-state ({rdy, val})
  logic [DATA_W:0]        w_e_s1     [NUM_ENTRIES];
  logic [DATA_W:0]        w_e_s2     [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_alloc;
  logic [LANE_W-1:0]      w_alloc_lane [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_ready;
  logic [TAG_W-1:0]       w_age      [NUM_ENTRIES];
  logic [OCC_W-1:0]       w_rank     [NUM_ENTRIES];
  logic [IDX_W-1:0]       w_sel      [ISSUE_WIDTH];
  logic [NUM_ENTRIES-1:0] w_issued;

  // Lowest-index CDB port wins when several carry the same tag, hence the
  // descending scan that lets the lower ports overwrite the higher ones.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]            tag,
    input logic                        rdy,
    input logic [DATA_W-1:0]           val,
    input logic [CDB_WIDTH-1:0]        cv,
    input logic [CDB_WIDTH*TAG_W-1:0]  ct,
    input logic [CDB_WIDTH*DATA_W-1:0] cd
  );
    logic [DATA_W:0] res;
    res = {rdy, val};
    if (!rdy) begin
      for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
        if (cv[c] && (ct[c*TAG_W +: TAG_W] == tag)) begin
          res = {1'b1, cd[c*DATA_W +: DATA_W]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_occ = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_occ = w_occ + OCC_W'(r_valid[e]);
    end
  end

  assign o_occupancy = w_occ;

  // Free count is taken at cycle start; slots vacated by this cycle's issue
  // only become visible next cycle.
  always_comb begin
    int free_n;
    free_n = NUM_ENTRIES - int'(w_occ);
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      o_disp_rdy[l] = !i_flush && (free_n >= l + 1);
    end
  end

  always_comb begin
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      w_l_tag[l]    = i_disp_rob_tag[l*TAG_W +: TAG_W];
      w_l_s1_tag[l] = i_disp_src1_tag[l*TAG_W +: TAG_W];
      w_l_s2_tag[l] = i_disp_src2_tag[l*TAG_W +: TAG_W];
      w_l_pl[l]     = i_disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
      w_l_s1[l]     = snoop(w_l_s1_tag[l], i_disp_src1_rdy[l],
                            i_disp_src1_val[l*DATA_W +: DATA_W],
                            i_cdb_valid, i_cdb_tag, i_cdb_data);
      w_l_s2[l]     = snoop(w_l_s2_tag[l], i_disp_src2_rdy[l],
                            i_disp_src2_val[l*DATA_W +: DATA_W],
                            i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_e_s1[e] = snoop(r_s1_tag[e], r_s1_rdy[e], r_s1_val[e],
                        i_cdb_valid, i_cdb_tag, i_cdb_data);
      w_e_s2[e] = snoop(r_s2_tag[e], r_s2_rdy[e], r_s2_val[e],
                        i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
  end

  // Accepted lanes, in lane order, claim the lowest-index free entries.
  always_comb begin
    logic [NUM_ENTRIES-1:0] taken;
    logic                   found;
    w_alloc = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_alloc_lane[e] = '0;
    end
    taken = r_valid;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      found = 1'b0;
      if (i_disp_valid[l] && o_disp_rdy[l]) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (!found && !taken[e]) begin
            found           = 1'b1;
            taken[e]        = 1'b1;
            w_alloc[e]      = 1'b1;
            w_alloc_lane[e] = LANE_W'(l);
          end
        end
      end
    end
  end

  // Rank = number of ready entries older than this one. The k-th FU port
  // that is ready takes the ready entry of rank k, so ports never share one.
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_ready[e] = r_valid[e] && r_s1_rdy[e] && r_s2_rdy[e];
      w_age[e]   = r_rob_tag[e] - i_rob_head;
    end
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_rank[e] = '0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (w_ready[j] && (w_age[j] < w_age[e])) begin
          w_rank[e] = w_rank[e] + OCC_W'(1);
        end
      end
    end
  end

  always_comb begin
    int   k;
    logic found;
    k           = 0;
    o_iss_valid = '0;
    w_issued    = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      w_sel[p] = '0;
      found    = 1'b0;
      if (i_fu_rdy[p] && !i_flush) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (!found && w_ready[e] && (int'(w_rank[e]) == k)) begin
            found    = 1'b1;
            w_sel[p] = IDX_W'(e);
          end
        end
        k = k + 1;
      end
      if (found) begin
        o_iss_valid[p]     = 1'b1;
        w_issued[w_sel[p]] = 1'b1;
      end
    end
  end

  always_comb begin
    o_iss_rob_tag  = '0;
    o_iss_src1_val = '0;
    o_iss_src2_val = '0;
    o_iss_payload  = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (o_iss_valid[p]) begin
        o_iss_rob_tag[p*TAG_W +: TAG_W]          = r_rob_tag[w_sel[p]];
        o_iss_src1_val[p*DATA_W +: DATA_W]       = r_s1_val[w_sel[p]];
        o_iss_src2_val[p*DATA_W +: DATA_W]       = r_s2_val[w_sel[p]];
        o_iss_payload[p*PAYLOAD_W +: PAYLOAD_W]  = r_payload[w_sel[p]];
      end
    end
  end

  // An issuing entry ignores any CDB hit; it is dropped at this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid  <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_rob_tag[e] <= '0;
        r_s1_tag[e]  <= '0;
        r_s2_tag[e]  <= '0;
        r_s1_val[e]  <= '0;
        r_s2_val[e]  <= '0;
        r_payload[e] <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (w_issued[e]) begin
          r_valid[e] <= 1'b0;
        end else if (w_alloc[e]) begin
          r_valid[e]                 <= 1'b1;
          r_rob_tag[e]               <= w_l_tag[w_alloc_lane[e]];
          r_s1_tag[e]                <= w_l_s1_tag[w_alloc_lane[e]];
          r_s2_tag[e]                <= w_l_s2_tag[w_alloc_lane[e]];
          {r_s1_rdy[e], r_s1_val[e]} <= w_l_s1[w_alloc_lane[e]];
          {r_s2_rdy[e], r_s2_val[e]} <= w_l_s2[w_alloc_lane[e]];
          r_payload[e]               <= w_l_pl[w_alloc_lane[e]];
        end else if (r_valid[e]) begin
          {r_s1_rdy[e], r_s1_val[e]} <= w_e_s1[e];
          {r_s2_rdy[e], r_s2_val[e]} <= w_e_s2[e];
        end
      end
    end
  end

`ifdef RS_PERF_CNT_EN
  logic [32:0] w_iss_sum;

  always_comb begin
    logic [32:0] n;
    n = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      n = n + 33'(o_iss_valid[p]);
    end
    w_iss_sum = {1'b0, o_perf_issued} + n;
  end

  // Both counters saturate; flush does not clear them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_full_cycles <= '0;
      o_perf_issued      <= '0;
    end else begin
      if ((w_occ == OCC_W'(NUM_ENTRIES)) && (|i_disp_valid) &&
          (o_perf_full_cycles != 32'hFFFF_FFFF)) begin
        o_perf_full_cycles <= o_perf_full_cycles + 32'd1;
      end
      o_perf_issued <= w_iss_sum[32] ? 32'hFFFF_FFFF : w_iss_sum[31:0];
    end
  end
`endif

endmodule

// File: doc/age_ordered_rs.md
Name: age_ordered_rs

Overview:
- Parametrised reservation station; successor to the fixed two-issue ALU station in the issue stage.
- Supports configurable dispatch width, issue width, CDB snoop width and depth.
- Selects oldest-first by ROB age relative to rob_head.
- Sits between dispatch and execute; one instance per FU class (ALU, MDU, future FP).

Parameters:
NUM_ENTRIES, 8, station depth (>= DISPATCH_WIDTH, >= 2)
DISPATCH_WIDTH, 2, dispatch lanes per cycle
ISSUE_WIDTH, 2, FU issue ports
CDB_WIDTH, 2, wakeup broadcast ports
TAG_W, 5, ROB tag width
DATA_W, 32, operand width
PAYLOAD_W, 32, opaque control bits (opcode/funct/imm), carried untouched

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all entries
disp_valid  in  DISPATCH_WIDTH  lane request
disp_rdy  out  DISPATCH_WIDTH  lane may write
disp_rob_tag  in  DISPATCH_WIDTH x TAG_W  destination ROB tag
disp_src1_tag / disp_src2_tag  in  DISPATCH_WIDTH x TAG_W  producer tags
disp_src1_rdy / disp_src2_rdy  in  DISPATCH_WIDTH  operand already valid
disp_src1_val / disp_src2_val  in  DISPATCH_WIDTH x DATA_W  operand values
disp_payload  in  DISPATCH_WIDTH x PAYLOAD_W  control bits
fu_rdy  in  ISSUE_WIDTH  FU accepts this cycle
iss_valid  out  ISSUE_WIDTH  issue fire (implies fu_rdy)
iss_rob_tag  out  ISSUE_WIDTH x TAG_W
iss_src1_val / iss_src2_val  out  ISSUE_WIDTH x DATA_W
iss_payload  out  ISSUE_WIDTH x PAYLOAD_W
cdb_valid  in  CDB_WIDTH
cdb_tag  in  CDB_WIDTH x TAG_W
cdb_data  in  CDB_WIDTH x DATA_W
rob_head  in  TAG_W  oldest in-flight ROB tag
occupancy  out  clog2(NUM_ENTRIES+1)  valid entry count

Behaviour:
- Entry state: valid, rob_tag, src{1,2}_{tag,rdy,val}, payload.
- Reset: all entries invalid, occupancy = 0, iss_valid = 0, disp_rdy = all 1s.
- disp_rdy:
  - disp_rdy[i] = (free >= i+1) && !flush, where free is NUM_ENTRIES - occupancy at cycle start.
  - Entries freed by issue this cycle are not reusable until the next cycle.
- Dispatch:
  - Lanes with valid & rdy allocate the lowest-index free entries, in lane order.
  - Entry becomes valid at the next edge.
  - A lane with valid & !rdy is dropped (dispatch holds it).
- Wakeup:
  - Each valid entry compares unready source tags against all cdb ports.
  - On match, it captures cdb_data and sets src_rdy at the edge.
  - Dispatching operands are snooped the same way in the dispatch cycle, so no wakeup is lost.
  - If multiple CDB ports match the same tag, the lowest CDB index wins (should not occur).
- Ready:
  - An entry is ready when valid and both src_rdy are set in its registered state.
  - Wakeup-to-issue is 1 cycle minimum.
- Select:
  - age = (rob_tag - rob_head) mod 2^TAG_W; smaller is older; tags are unique, so there are no ties.
  - Ready entries are sorted by age.
  - The oldest goes to the lowest-index port with fu_rdy=1, the next oldest to the next such port, and so on.
  - Ports with fu_rdy=0 get iss_valid=0.
- Issue outputs:
  - Combinational from registered entry state.
  - An issued entry is invalidated at the edge.
  - No entry is ever issued on two ports.
- Simultaneous events:
  - Issue and dispatch in the same cycle: occupancy' = occupancy + dispatched - issued.
  - A CDB match on an entry being issued this cycle is ignored (it is already ready).
- Flush:
  - While flush=1: iss_valid = 0 and disp_rdy = 0.
  - At the edge, all entries are invalid and occupancy = 0.
  - flush has priority over dispatch and wakeup.
- Full: occupancy == NUM_ENTRIES gives disp_rdy = 0.
- Empty: iss_valid = 0.
- rob_head wraps mod 2^TAG_W; age arithmetic is TAG_W-bit unsigned.
- Async reset mid-operation discards all entries immediately.

Optional Feature:
- Macro RS_PERF_CNT_EN.
- Defined:
  - Adds output perf_full_cycles (32b): counts cycles with occupancy == NUM_ENTRIES and any disp_valid.
  - Adds output perf_issued (32b): counts issue fires, summed over ports per cycle.
  - Both saturate at all-ones, reset to 0 on rst, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Dispatch 2 entries with both src ready, tags 3 and 4, rob_head=3, fu_rdy=2'b11 -> next cycle iss_valid=2'b11, port0 tag 3, port1 tag 4, occupancy 2 then 0.
- Dispatch tag 7 waiting on src1 tag 2; cdb_valid[1]=1, cdb_tag=2, data 0xDEADBEEF -> issues the cycle after the CDB with iss_src1_val=0xDEADBEEF.
- Dispatch with src2 tag 5 while cdb broadcasts tag 5 in the same cycle -> entry captures the value and issues next cycle.
- rob_head=30, ready tags 1 and 31, single fu_rdy=2'b01 -> tag 31 issues first, tag 1 the following cycle.
- Fill 8 entries, none ready -> disp_rdy=0, occupancy=8; assert flush 1 cycle -> occupancy 0, disp_rdy=2'b11, no issue ever occurs.
- fu_rdy=2'b10 with 1 ready entry -> issues on port 1; port 0 iss_valid stays 0.
